te_block_builder: RTL

Reader-side stage of the CVA6 trace connector. It pops `uop_entry_s` records (with paired `exc_info_s`) from the uop FIFO and compresses runs of retired instructions into E-Trace instruction blocks (`iaddr`, `iretire`, `ilastsize`, `itype`, `priv`, `cause`, `tval`). Blocks go to the trace encoder through a registered valid/ready port.

---
 rtl/te_block_builder_if.sv | 49 ++++
 rtl/te_block_builder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/te_block_builder_if.sv
// te_block_builder_if: uop FIFO head/pop and E-Trace block output bundle
interface te_block_builder_if;
`ifdef TRDB_ARCH64
    localparam int XLEN = 64;
`else
    localparam int XLEN = 32;
`endif
    localparam int IRETIRE_LEN = 32;
    localparam int ITYPE_LEN = 3;
    localparam int PRIV_LEN = 2;
    localparam int CAUSE_LEN = 5;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [ITYPE_LEN-1:0] itype;
        logic                 compressed;
        logic [PRIV_LEN-1:0]  priv;
    } uop_entry_s;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
    } exc_info_s;

    logic                   uop_valid_i;
    uop_entry_s             uop_entry_i;
    exc_info_s              exc_info_i;
    logic                   uop_pop_o;
    logic                   block_valid_o;
    logic                   block_ready_i;
    logic [XLEN-1:0]        iaddr_o;
    logic [IRETIRE_LEN-1:0] iretire_o;
    logic                   ilastsize_o;
    logic [ITYPE_LEN-1:0]   itype_o;
    logic [PRIV_LEN-1:0]    priv_o;
    logic [CAUSE_LEN-1:0]   cause_o;
    logic [XLEN-1:0]        tval_o;

    modport master (
        output uop_valid_i, uop_entry_i, exc_info_i, block_ready_i,
        input  uop_pop_o, block_valid_o, iaddr_o, iretire_o, ilastsize_o, itype_o, priv_o, cause_o, tval_o
    );

    modport slave (
        input  uop_valid_i, uop_entry_i, exc_info_i, block_ready_i,
        output uop_pop_o, block_valid_o, iaddr_o, iretire_o, ilastsize_o, itype_o, priv_o, cause_o, tval_o
    );
endinterface

// File: rtl/te_block_builder.sv
// te_block_builder: compresses retired uops into E-Trace instruction blocks
module te_block_builder (
    input logic               clk_i,
    input logic               rst_ni,
    te_block_builder_if.slave bus
);
`ifdef TRDB_ARCH64
    localparam int XLEN = 64;
`else
    localparam int XLEN = 32;
`endif
    localparam int IRETIRE_LEN = 32;
    localparam int CAUSE_LEN = 5;

    typedef enum logic [2:0] {STD = 3'd0, EXC = 3'd1, INT = 3'd2, ERET = 3'd3,
                              NTB = 3'd4, TB = 3'd5, UIJ = 3'd6, RES = 3'd7} itype_e;
    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;

    state_e                 state, state_n;
    logic [XLEN-1:0]        acc_iaddr, acc_iaddr_n;
    logic [IRETIRE_LEN-1:0] acc_cnt, acc_cnt_n;
    logic                   acc_last, acc_last_n;
    logic [1:0]             acc_priv, acc_priv_n;

    logic                   emit;
    logic [XLEN-1:0]        e_iaddr, e_tval;
    logic [IRETIRE_LEN-1:0] e_cnt;
    logic                   e_last;
    itype_e                 e_itype;
    logic [1:0]             e_priv;
    logic [CAUSE_LEN-1:0]   e_cause;

    itype_e                 it;
    logic [IRETIRE_LEN-1:0] size, sum;
    logic                   stall, priv_flush, pop;
    logic                   entry_unused;

    assign entry_unused = bus.uop_entry_i.valid;
    assign it = itype_e'(bus.uop_entry_i.itype);
    assign size = bus.uop_entry_i.compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    assign sum = acc_cnt + size;
    assign stall = bus.block_valid_o & ~bus.block_ready_i;
    assign priv_flush = (state == COUNT) & bus.uop_valid_i & (bus.uop_entry_i.priv != acc_priv);
    // Reset gates the pop so the FIFO is never drained while the state is held
    assign pop = rst_ni & bus.uop_valid_i & ~stall & ~priv_flush;
    assign bus.uop_pop_o = pop;

    // Next-state, accumulator update and candidate block contents
    always_comb begin
        state_n = state;
        acc_iaddr_n = acc_iaddr;
        acc_cnt_n = acc_cnt;
        acc_last_n = acc_last;
        acc_priv_n = acc_priv;
        emit = 1'b0;
        e_iaddr = acc_iaddr;
        e_cnt = acc_cnt;
        e_last = acc_last;
        e_itype = STD;
        e_priv = acc_priv;
        e_cause = '0;
        e_tval = '0;
        if (priv_flush && !stall) begin
            emit = 1'b1;
            state_n = IDLE;
        end else if (pop && state == IDLE) begin
            e_iaddr = bus.uop_entry_i.pc;
            e_priv = bus.uop_entry_i.priv;
            e_itype = it;
            e_cnt = size;
            e_last = ~bus.uop_entry_i.compressed;
            case (it)
                STD: begin
                    state_n = COUNT;
                    acc_iaddr_n = bus.uop_entry_i.pc;
                    acc_cnt_n = size;
                    acc_last_n = ~bus.uop_entry_i.compressed;
                    acc_priv_n = bus.uop_entry_i.priv;
                end
                RES: ;
                EXC, INT: begin
                    emit = 1'b1;
                    e_cnt = '0;
                    e_last = 1'b0;
                    e_cause = bus.exc_info_i.cause;
                    e_tval = bus.exc_info_i.tval;
                end
                default: emit = 1'b1;
            endcase
        end else if (pop) begin
            e_cnt = sum;
            e_last = ~bus.uop_entry_i.compressed;
            e_itype = it;
            case (it)
                STD: begin
                    acc_cnt_n = sum;
                    acc_last_n = ~bus.uop_entry_i.compressed;
                    // Close the block before another 32-bit entry could overflow the counter
                    if (sum > ~IRETIRE_LEN'(2)) begin
                        emit = 1'b1;
                        state_n = IDLE;
                    end
                end
                RES: ;
                EXC, INT: begin
                    emit = 1'b1;
                    state_n = IDLE;
                    e_cnt = acc_cnt;
                    e_last = acc_last;
                    e_cause = bus.exc_info_i.cause;
                    e_tval = bus.exc_info_i.tval;
                end
                default: begin
                    emit = 1'b1;
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and accumulators; frozen while the output is stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            acc_iaddr <= '0;
            acc_cnt <= '0;
            acc_last <= 1'b0;
            acc_priv <= '0;
        end else if (!stall) begin
            state <= state_n;
            acc_iaddr <= acc_iaddr_n;
            acc_cnt <= acc_cnt_n;
            acc_last <= acc_last_n;
            acc_priv <= acc_priv_n;
        end
    end

    // Output block register; loads when empty or being accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.block_valid_o <= 1'b0;
            bus.iaddr_o <= '0;
            bus.iretire_o <= '0;
            bus.ilastsize_o <= 1'b0;
            bus.itype_o <= '0;
            bus.priv_o <= '0;
            bus.cause_o <= '0;
            bus.tval_o <= '0;
        end else if (!stall) begin
            bus.block_valid_o <= emit;
            if (emit) begin
                bus.iaddr_o <= e_iaddr;
                bus.iretire_o <= e_cnt;
                bus.ilastsize_o <= e_last;
                bus.itype_o <= e_itype;
                bus.priv_o <= e_priv;
                bus.cause_o <= e_cause;
                bus.tval_o <= e_tval;
            end
        end
    end
endmodule
